// File: rtl/uart_rx_buf_writer_if.sv
// Byte stream from the uart receiver and the write port into buf_ram.
// The writer block is the slave: it consumes rx_* and drives ram_*.
interface uart_rx_buf_writer_if #(
  parameter int ADDR_W = 9
);
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_error;
  logic              ram_wen;
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_wdata;

  modport master (
    output rx_valid, rx_data, rx_error,
    input  ram_wen, ram_addr, ram_wdata
  );

  modport slave (
    input  rx_valid, rx_data, rx_error,
    output ram_wen, ram_addr, ram_wdata
  );
endinterface

// File: rtl/uart_rx_buf_writer.sv
// Writes received uart bytes into a circular buffer RAM, tracks fill level against
// the reader's drain pointer, and drives cts flow control with hysteresis.
module uart_rx_buf_writer #(
  parameter int ADDR_W     = 9,
  parameter int HIGH_WATER = 448,
  parameter int LOW_WATER  = 256
) (
  input  logic                 clk,
  input  logic                 rst_n,
  uart_rx_buf_writer_if.slave  bus,
  input  logic [ADDR_W:0]      rd_ptr,
  input  logic                 clear,
  output logic [ADDR_W:0]      wr_ptr,
  output logic [ADDR_W:0]      level,
  output logic                 full,
  output logic                 empty,
  output logic                 cts,
  output logic                 overflow,
  output logic [7:0]           err_count
);

  localparam logic [ADDR_W:0] DEPTH_C = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] HIGH_C  = (ADDR_W+1)'(HIGH_WATER);
  localparam logic [ADDR_W:0] LOW_C   = (ADDR_W+1)'(LOW_WATER);

  localparam logic [0:0] FLOW_OFF = 1'b0;
  localparam logic [0:0] FLOW_ON  = 1'b1;

  logic [ADDR_W:0]   wr_ptr_r;
  logic              ram_wen_r;
  logic [ADDR_W-1:0] ram_addr_r;
  logic [7:0]        ram_wdata_r;
  logic              overflow_r;
  logic [7:0]        err_count_r;
  logic [0:0]        flow_state_r;
  logic [0:0]        flow_next_s;

  logic [ADDR_W:0]   level_s;
  logic              blocked_s;
  logic              byte_ok_s;
  logic              accept_s;
  logic              drop_s;

  // Fill level and write qualification; a level beyond DEPTH is treated as full.
  always_comb begin
    level_s   = wr_ptr_r - rd_ptr;
    blocked_s = (level_s >= DEPTH_C);
    byte_ok_s = bus.rx_valid & ~bus.rx_error & ~clear;
    accept_s  = byte_ok_s & ~blocked_s;
    drop_s    = byte_ok_s & blocked_s;
  end

  // Hysteresis flow-control next state, evaluated on the current level.
  always_comb begin
    flow_next_s = flow_state_r;
    case (flow_state_r)
      FLOW_ON: begin
        if (level_s >= HIGH_C) begin
          flow_next_s = FLOW_OFF;
        end else begin
          flow_next_s = FLOW_ON;
        end
      end
      FLOW_OFF: begin
        if (level_s <= LOW_C) begin
          flow_next_s = FLOW_ON;
        end else begin
          flow_next_s = FLOW_OFF;
        end
      end
      default: flow_next_s = FLOW_ON;
    endcase
  end

  // RAM write port: one-cycle wen pulse per accepted byte, address/data hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_wen_r   <= 1'b0;
      ram_addr_r  <= '0;
      ram_wdata_r <= 8'h00;
      wr_ptr_r    <= '0;
    end else if (clear) begin
      ram_wen_r   <= 1'b0;
      wr_ptr_r    <= rd_ptr;
    end else if (accept_s) begin
      ram_wen_r   <= 1'b1;
      ram_addr_r  <= wr_ptr_r[ADDR_W-1:0];
      ram_wdata_r <= bus.rx_data;
      wr_ptr_r    <= wr_ptr_r + {{ADDR_W{1'b0}}, 1'b1};
    end else begin
      ram_wen_r   <= 1'b0;
    end
  end

  // Debug status: sticky overflow and saturating receive-error counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_r  <= 1'b0;
      err_count_r <= 8'h00;
    end else if (clear) begin
      overflow_r  <= 1'b0;
      err_count_r <= 8'h00;
    end else begin
      if (drop_s) begin
        overflow_r <= 1'b1;
      end
      if (bus.rx_error && (err_count_r != 8'hFF)) begin
        err_count_r <= err_count_r + 8'h01;
      end
    end
  end

  // Flow-control state register; a flush always reopens the sender.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flow_state_r <= FLOW_ON;
    end else if (clear) begin
      flow_state_r <= FLOW_ON;
    end else begin
      flow_state_r <= flow_next_s;
    end
  end

  assign bus.ram_wen   = ram_wen_r;
  assign bus.ram_addr  = ram_addr_r;
  assign bus.ram_wdata = ram_wdata_r;
  assign wr_ptr        = wr_ptr_r;
  assign level         = level_s;
  assign full          = (level_s == DEPTH_C);
  assign empty         = (level_s == '0);
  assign cts           = (flow_state_r == FLOW_ON);
  assign overflow      = overflow_r;
  assign err_count     = err_count_r;

endmodule

// File: tb/tb_uart_rx_buf_writer.sv
// Randomized bench for uart_rx_buf_writer against a pointer-arithmetic reference model.
module tb_uart_rx_buf_writer;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] rd_ptr;
  logic       clear;
  logic [9:0] wr_ptr;
  logic [9:0] level;
  logic       full;
  logic       empty;
  logic       cts;
  logic       overflow;
  logic [7:0] err_count;

  always #5 clk = ~clk;

  uart_rx_buf_writer_if #(.ADDR_W(9)) bus ();

  uart_rx_buf_writer #(.ADDR_W(9), .HIGH_WATER(448), .LOW_WATER(256)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .rd_ptr(rd_ptr), .clear(clear),
    .wr_ptr(wr_ptr), .level(level), .full(full), .empty(empty), .cts(cts),
    .overflow(overflow), .err_count(err_count)
  );

  int checks = 0;
  int failures = 0;

  // reference model state
  int m_wr, m_ovf, m_err, m_cts, m_wen, m_addr, m_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int m_level();
    return (m_wr - int'(rd_ptr)) & 1023;
  endfunction

  task automatic model_reset();
    m_wr = 0; m_ovf = 0; m_err = 0; m_cts = 1; m_wen = 0; m_addr = 0; m_data = 0;
  endtask

  task automatic check_all();
    int lvl;
    lvl = m_level();
    chk("ram_wen", bus.ram_wen, m_wen);
    chk("ram_addr", bus.ram_addr, m_addr);
    chk("ram_wdata", bus.ram_wdata, m_data);
    chk("wr_ptr", wr_ptr, m_wr);
    chk("level", level, lvl);
    chk("full", full, (lvl == 512) ? 1 : 0);
    chk("empty", empty, (lvl == 0) ? 1 : 0);
    chk("cts", cts, m_cts);
    chk("overflow", overflow, m_ovf);
    chk("err_count", err_count, m_err);
  endtask

  // one clock: drive inputs, update model at the edge, check at the falling edge
  task automatic step(input logic v, input logic [7:0] d, input logic e, input logic c);
    int lvl;
    bus.rx_valid = v; bus.rx_data = d; bus.rx_error = e; clear = c;
    @(posedge clk);
    lvl = m_level();
    m_wen = 0;
    if (c) begin
      m_wr = int'(rd_ptr); m_ovf = 0; m_err = 0; m_cts = 1;
    end else begin
      if (e) m_err = (m_err < 255) ? m_err + 1 : 255;
      if (v && !e) begin
        if (lvl >= 512) m_ovf = 1;
        else begin
          m_wen = 1; m_addr = m_wr % 512; m_data = int'(d); m_wr = (m_wr + 1) % 1024;
        end
      end
      if (m_cts == 1 && lvl >= 448) m_cts = 0;
      else if (m_cts == 0 && lvl <= 256) m_cts = 1;
    end
    @(negedge clk);
    check_all();
  endtask

  task automatic idle();
    step(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  initial begin
    int lvl;
    logic [8:0] wrap_addr [4];
    wrap_addr[0] = 9'd510; wrap_addr[1] = 9'd511; wrap_addr[2] = 9'd0; wrap_addr[3] = 9'd1;

    rst_n = 1'b0; rd_ptr = 10'd0; clear = 1'b0;
    bus.rx_valid = 1'b0; bus.rx_data = 8'h00; bus.rx_error = 1'b0;
    model_reset();
    #12;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    idle();

    // three directed bytes
    step(1'b1, 8'h41, 1'b0, 1'b0);
    chk("abc_addr0", bus.ram_addr, 32'd0);
    step(1'b1, 8'h42, 1'b0, 1'b0);
    step(1'b1, 8'h43, 1'b0, 1'b0);
    chk("abc_data2", bus.ram_wdata, 32'h43);
    chk("abc_level", level, 32'd3);
    idle();

    // random traffic with a moving reader and occasional errors/flushes
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        lvl = m_level();
        rd_ptr = 10'(m_wr - int'($urandom_range(0, lvl)));
      end
      step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 9) == 0),
           1'($urandom_range(0, 79) == 0));
    end

    // high-water / low-water hysteresis
    rd_ptr = 10'd0;
    step(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 448; i++) begin
      step(1'b1, 8'($urandom), 1'b0, 1'b0);
      if (i == 300) rd_ptr = 10'd0;
    end
    chk("hw_level", level, 32'd448);
    chk("hw_cts_still_on", cts, 32'd1);
    idle();
    chk("hw_cts_off", cts, 32'd0);
    rd_ptr = 10'd192;
    idle();
    chk("lw_cts_on", cts, 32'd1);

    // fill to full then overflow, then flush
    rd_ptr = 10'd0;
    for (int i = 0; i < 64; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0);
    chk("full_flag", full, 32'd1);
    step(1'b1, 8'h55, 1'b0, 1'b0);
    chk("ovf_set", overflow, 32'd1);
    chk("ovf_wr_ptr", wr_ptr, 32'd512);
    idle();
    step(1'b1, 8'h66, 1'b0, 1'b1);
    chk("clear_ovf", overflow, 32'd0);
    chk("clear_level", level, 32'd0);

    // pointer wrap
    rd_ptr = 10'd1022;
    step(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 8'($urandom), 1'b0, 1'b0);
      chk("wrap_addr", bus.ram_addr, wrap_addr[i]);
    end
    chk("wrap_wr_ptr", wr_ptr, 32'd2);
    chk("wrap_level", level, 32'd4);

    // error storm with valid bytes: nothing written, counter saturates
    for (int i = 0; i < 300; i++) step(1'b1, 8'($urandom), 1'b1, 1'b0);
    chk("err_sat", err_count, 32'd255);

    // reader ran ahead: level 600 is treated as full
    rd_ptr = 10'(m_wr - 600);
    step(1'b1, 8'hA5, 1'b0, 1'b0);
    chk("overrun_no_write", bus.ram_wen, 32'd0);
    idle();
    chk("overrun_cts", cts, 32'd0);

    // async reset while a write pulse is on the bus
    rd_ptr = 10'd0;
    step(1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b1, 8'h77, 1'b0, 1'b0);
    chk("midwr_wen", bus.ram_wen, 32'd1);
    #2 rst_n = 1'b0;
    #1 chk("async_wen_drop", bus.ram_wen, 32'd0);
    model_reset();
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    bus.rx_valid = 1'b0;
    idle();
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
